time_set_controller: RTL

Sequences the clock's user interface by turning three buttons into mode changes, field increment/decrement pulses and a long-press system reset.
- Sits between the button inputs and the hours/minutes/seconds counter datapath.
- Selects which field is being set, pauses the run state while setting, and returns to run on a short press or after an idle timeout.
- Replaces standalone hold-to-reset logic: a long press on the centre button issues the system reset pulse.

---
 rtl/clock_pkg.sv | 25 ++
 rtl/btn_sync_edge.sv | 32 +++
 rtl/time_set_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared mode encoding for the time-set controller, counter datapath and display mux.
package clock_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2,
        MODE_SET_SEC = 2'd3
    } mode_t;

    // Short-press sequence: RUN -> HR -> MIN -> SEC -> RUN
    function automatic mode_t next_mode(input mode_t m);
        mode_t r;
        case (m)
            MODE_RUN:     r = MODE_SET_HR;
            MODE_SET_HR:  r = MODE_SET_MIN;
            MODE_SET_MIN: r = MODE_SET_SEC;
            default:      r = MODE_RUN;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button plus a history flop for edges.
// Level/rise/fall are valid two clocks after the pin changes; anything registered
// from them lands on the third clock.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1, r_s2, r_s3;

    // Synchroniser chain; reset to 0 so a button held through reset reads as a new press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/time_set_controller.sv
// Button sequencer for the clock UI: mode selection, inc/dec pulses with
// auto-repeat, idle fallback to RUN and btnC long-press system reset.
// Optional: define TSC_BLINK_EN to build the blink gate for the selected field.
module time_set_controller
    import clock_pkg::*;
#(
    parameter int unsigned HOLD_SECONDS = 3,
    parameter int unsigned REPEAT_DELAY = 1,
    parameter int unsigned IDLE_TIMEOUT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnC,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       tick_1s,
    input  logic       tick_rep,
    output logic [1:0] mode,
    output logic       clock_run,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       sys_reset,
    output logic       blink_en
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_SECONDS);
    localparam logic [CNT_W-1:0] HOLD_M1  = CNT_W'(HOLD_SECONDS - 1);
    localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] IDLE_M1  = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic             IDLE_ON  = (IDLE_TIMEOUT != 0);

    logic w_c_lvl, w_c_rise, w_c_fall;
    logic w_u_lvl, w_u_rise, w_u_fall;
    logic w_d_lvl, w_d_rise, w_d_fall;

    btn_sync_edge u_sync_c (.clk(clk), .rst(rst), .i_btn(btnC),
                            .o_level(w_c_lvl), .o_rise(w_c_rise), .o_fall(w_c_fall));
    btn_sync_edge u_sync_u (.clk(clk), .rst(rst), .i_btn(btnU),
                            .o_level(w_u_lvl), .o_rise(w_u_rise), .o_fall(w_u_fall));
    btn_sync_edge u_sync_d (.clk(clk), .rst(rst), .i_btn(btnD),
                            .o_level(w_d_lvl), .o_rise(w_d_rise), .o_fall(w_d_fall));

    mode_t            r_mode;
    logic             r_clock_run, r_inc, r_dec, r_sys_reset;
    logic [CNT_W-1:0] r_hold_cnt, r_rep_cnt, r_idle_cnt;
    logic             r_long, r_arm, r_dir_up;

    logic  w_set, w_any_lvl, w_both;
    logic  w_hold_hit, w_short, w_idle_hit, w_mode_chg;
    logic  w_u_start, w_d_start, w_dir_lvl, w_rep_fire;
    mode_t w_mode_nxt;

    assign w_set     = (r_mode != MODE_RUN);
    assign w_any_lvl = w_c_lvl | w_u_lvl | w_d_lvl;
    assign w_both    = w_u_lvl & w_d_lvl;

    // Long press: fires on the tick that brings hold_cnt to HOLD_SECONDS, once per hold
    assign w_hold_hit = w_c_lvl & ~w_c_rise & tick_1s & ~r_long & (r_hold_cnt == HOLD_M1);
    assign w_short    = w_c_fall & ~r_long;
    assign w_idle_hit = IDLE_ON & w_set & ~w_any_lvl & tick_1s & (r_idle_cnt == IDLE_M1);
    assign w_mode_chg = w_hold_hit | w_short | w_idle_hit;

    // A fresh single-button press starts a new inc/dec run
    assign w_u_start  = w_u_rise & ~w_d_lvl;
    assign w_d_start  = w_d_rise & ~w_u_lvl;
    assign w_dir_lvl  = r_dir_up ? w_u_lvl : w_d_lvl;
    assign w_rep_fire = r_arm & w_dir_lvl & ~w_both & tick_rep & (r_rep_cnt == REP_MAX)
                        & ~w_u_start & ~w_d_start;

    // Next mode in priority order: long press > short press > idle timeout
    always_comb begin
        w_mode_nxt = r_mode;
        if (w_hold_hit)
            w_mode_nxt = MODE_RUN;
        else if (w_short)
            w_mode_nxt = next_mode(r_mode);
        else if (w_idle_hit)
            w_mode_nxt = MODE_RUN;
    end

    // Mode, registered outputs and the hold/repeat/idle counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode      <= MODE_RUN;
            r_clock_run <= 1'b1;
            r_inc       <= 1'b0;
            r_dec       <= 1'b0;
            r_sys_reset <= 1'b0;
            r_hold_cnt  <= '0;
            r_rep_cnt   <= '0;
            r_idle_cnt  <= '0;
            r_long      <= 1'b0;
            r_arm       <= 1'b0;
            r_dir_up    <= 1'b0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_clock_run <= (w_mode_nxt == MODE_RUN);
            r_sys_reset <= w_hold_hit;

            // Pulses are dropped in RUN and in any cycle that changes mode
            r_inc <= w_set & ~w_mode_chg & (w_u_start | (w_rep_fire & r_dir_up));
            r_dec <= w_set & ~w_mode_chg & (w_d_start | (w_rep_fire & ~r_dir_up));

            if (w_c_rise) begin
                r_hold_cnt <= '0;
                r_long     <= 1'b0;
            end else begin
                if (w_c_lvl && tick_1s && r_hold_cnt < HOLD_MAX)
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                if (w_hold_hit)
                    r_long <= 1'b1;
            end

            // Both buttons down disarms; only a new single press re-arms
            if (w_both || !w_set) begin
                r_arm     <= 1'b0;
                r_rep_cnt <= '0;
            end else if (w_u_start || w_d_start) begin
                r_arm     <= 1'b1;
                r_dir_up  <= w_u_start;
                r_rep_cnt <= '0;
            end else if (r_arm && (r_dir_up ? w_u_fall : w_d_fall)) begin
                r_arm     <= 1'b0;
            end else if (r_arm && tick_1s && r_rep_cnt < REP_MAX) begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end

            if (w_mode_chg || !w_set || w_any_lvl)
                r_idle_cnt <= '0;
            else if (tick_1s && r_idle_cnt != '1)
                r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign mode      = r_mode;
    assign clock_run = r_clock_run;
    assign inc_pulse = r_inc;
    assign dec_pulse = r_dec;
    assign sys_reset = r_sys_reset;

`ifdef TSC_BLINK_EN
    logic r_blink;

    // Blink toggles at the repeat rate while idle in a set mode; solid while adjusting
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_blink <= 1'b0;
        else if (w_mode_nxt == MODE_RUN)
            r_blink <= 1'b0;
        else if (w_u_lvl || w_d_lvl)
            r_blink <= 1'b1;
        else if (!w_c_lvl && tick_rep)
            r_blink <= ~r_blink;
    end

    assign blink_en = r_blink;
`else
    assign blink_en = 1'b0;
`endif

endmodule
